// File: rtl/dso_wave_reader_if.sv
// Point stream from dso_wave_reader to the plot/overlay logic: valid/ready,
// payload held stable while stalled.
interface dso_wave_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              pt_valid;
  logic              pt_ready;
  logic [ADDR_W-1:0] pt_x;
  logic [DATA_W-1:0] pt_y_lo;
  logic [DATA_W-1:0] pt_y_hi;
  logic              pt_last;

  modport master (
    output pt_valid, pt_x, pt_y_lo, pt_y_hi, pt_last,
    input  pt_ready
  );

  modport slave (
    input  pt_valid, pt_x, pt_y_lo, pt_y_hi, pt_last,
    output pt_ready
  );
endinterface

// File: rtl/dso_wave_reader.sv
// Waveform RAM read sequencer: H_POINTS reads/frame, frame_start->ram_rd_over = H_POINTS+RD_LAT+1 at full rate.
// Reads stall when FIFO + in-flight would overflow; define DSO_WAVE_SEG_EN for min/max segment points.

module dso_wave_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  output logic                       pop_vld,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign pop_vld = (count != '0);
  assign do_pop  = pop_rdy && pop_vld;
  assign do_push = push_vld && ((count != CW'(DEPTH)) || do_pop);
  assign pop_dat = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module dso_wave_reader #(
  parameter int H_POINTS   = 640,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  output logic                busy,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   wave_rd_addr,
  input  logic [DATA_W-1:0]   wave_rd_data,
  output logic                ram_rd_over,
  dso_wave_reader_if.master   pt
);
  localparam int                CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(H_POINTS - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [DATA_W-1:0] y_lo;
    logic [DATA_W-1:0] y_hi;
    logic              last;
  } pt_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_cur;
  logic [ADDR_W-1:0] rx_idx;
  logic [RD_LAT:1]   rd_sr;
  logic              start_acc;
  logic              issue;
  logic              pop;
  logic              push_vld;
  logic              head_vld;
  logic [CW-1:0]     fifo_count;
  int                inflight;
  logic [DATA_W-1:0] y;
  pt_t               push_dat;
  pt_t               head;

  assign start_acc = (state == S_IDLE) && frame_start;
  assign addr_cur  = (state == S_IDLE) ? '0 : idx;
  assign pop       = head_vld && pt.pt_ready;

  // Reads issued but not yet in the FIFO: the registered strobe plus every latency stage.
  always_comb begin
    inflight = int'(ram_rd_en);
    for (int i = 1; i <= RD_LAT; i++) inflight += int'(rd_sr[i]);
  end

  // A same-cycle pop frees a slot, which is what sustains one point per clock.
  assign issue = (start_acc || (state == S_READ)) &&
                 ((int'(fifo_count) - int'(pop) + inflight) < FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      ram_rd_en    <= 1'b0;
      wave_rd_addr <= '0;
      ram_rd_over  <= 1'b0;
    end else begin
      ram_rd_en   <= issue;
      ram_rd_over <= 1'b0;
      if (issue) begin
        wave_rd_addr <= addr_cur;
        idx          <= addr_cur + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            busy <= 1'b1;
            if (!issue) idx <= '0;
            state <= (issue && (addr_cur == LAST_X)) ? S_DRAIN : S_READ;
          end
        end
        S_READ: begin
          if (issue && (idx == LAST_X)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (inflight == 0) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            ram_rd_over <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sr  <= '0;
      rx_idx <= '0;
    end else begin
      rd_sr[1] <= ram_rd_en;
      for (int i = 2; i <= RD_LAT; i++) rd_sr[i] <= rd_sr[i-1];
      if (start_acc)     rx_idx <= '0;
      else if (push_vld) rx_idx <= rx_idx + 1'b1;
    end
  end

  assign push_vld = rd_sr[RD_LAT];
  assign y        = ~wave_rd_data;

`ifdef DSO_WAVE_SEG_EN
  logic [DATA_W-1:0] y_prev;

  always_ff @(posedge clk) begin
    if (rst)           y_prev <= '0;
    else if (start_acc) y_prev <= '0;
    else if (push_vld)  y_prev <= y;
  end

  always_comb begin
    push_dat.x    = rx_idx;
    push_dat.last = (rx_idx == LAST_X);
    if (rx_idx == '0) begin
      push_dat.y_lo = y;
      push_dat.y_hi = y;
    end else begin
      push_dat.y_lo = (y < y_prev) ? y : y_prev;
      push_dat.y_hi = (y < y_prev) ? y_prev : y;
    end
  end
`else
  always_comb begin
    push_dat.x    = rx_idx;
    push_dat.last = (rx_idx == LAST_X);
    push_dat.y_lo = y;
    push_dat.y_hi = y;
  end
`endif

  dso_wave_fifo #(
    .WIDTH ($bits(pt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (pt.pt_ready),
    .pop_vld  (head_vld),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  // Payload forced to zero when empty so the stream is clean out of reset.
  assign pt.pt_valid = head_vld;
  assign pt.pt_x     = head_vld ? head.x    : '0;
  assign pt.pt_y_lo  = head_vld ? head.y_lo : '0;
  assign pt.pt_y_hi  = head_vld ? head.y_hi : '0;
  assign pt.pt_last  = head_vld && head.last;
endmodule
